// File: rtl/qpu_dtcm_dma_pkg.sv
// rtl/qpu_dtcm_dma_pkg.sv - shared widths and FSM state encodings for the DTCM DMA initiator.
package qpu_dtcm_dma_pkg;

  localparam int QPU_DTCM_ADDR_WIDTH = 16;
  localparam int QPU_DTCM_DMA_LEN_W  = 16;

  typedef enum logic [2:0] {
    QPU_DMA_ST_IDLE  = 3'd0,
    QPU_DMA_ST_FETCH = 3'd1,
    QPU_DMA_ST_CMD   = 3'd2,
    QPU_DMA_ST_RSP   = 3'd3,
    QPU_DMA_ST_PUSH  = 3'd4,
    QPU_DMA_ST_DONE  = 3'd5
  } qpu_dma_state_e;

  function automatic logic [QPU_DTCM_ADDR_WIDTH-1:0] word_align(
      input logic [QPU_DTCM_ADDR_WIDTH-1:0] a);
    return {a[QPU_DTCM_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/qpu_dtcm_dma_if.sv
// rtl/qpu_dtcm_dma_if.sv - stream and ICB channels between the DMA (master) and its environment (slave).
interface qpu_dtcm_dma_if import qpu_dtcm_dma_pkg::*; #(
  parameter int AW = QPU_DTCM_ADDR_WIDTH
);
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_data;
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_data;
  logic          icb_cmd_valid;
  logic          icb_cmd_ready;
  logic [AW-1:0] icb_cmd_addr;
  logic          icb_cmd_read;
  logic [31:0]   icb_cmd_wdata;
  logic [3:0]    icb_cmd_wmask;
  logic          icb_rsp_valid;
  logic          icb_rsp_ready;
  logic [31:0]   icb_rsp_rdata;

  modport master (
    input  s_valid, s_data, m_ready, icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata,
    output s_ready, m_valid, m_data, icb_cmd_valid, icb_cmd_addr, icb_cmd_read,
           icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready
  );

  modport slave (
    output s_valid, s_data, m_ready, icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata,
    input  s_ready, m_valid, m_data, icb_cmd_valid, icb_cmd_addr, icb_cmd_read,
           icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready
  );
endinterface

// File: rtl/qpu_dtcm_dma.sv
// rtl/qpu_dtcm_dma.sv - single-channel ICB initiator moving words between a stream and the DTCM.
// Read mode (DTCM to stream) is built only when QPU_DTCM_DMA_READ_EN is defined.
module qpu_dtcm_dma import qpu_dtcm_dma_pkg::*; #(
  parameter int LEN_W = QPU_DTCM_DMA_LEN_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_start,
  input  logic                           cfg_read,
  input  logic [QPU_DTCM_ADDR_WIDTH-1:0] cfg_base,
  input  logic [LEN_W-1:0]               cfg_len,
  output logic                           busy,
  output logic                           done,
  output logic                           dma_active,
  qpu_dtcm_dma_if.master                 bus
);

  localparam int AW = QPU_DTCM_ADDR_WIDTH;

  qpu_dma_state_e state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [31:0]      wdata_q, wdata_d;
`ifdef QPU_DTCM_DMA_READ_EN
  logic             mode_q, mode_d;
  logic [31:0]      rdata_q, rdata_d;
`else
  logic             unused_inputs;
  assign unused_inputs = ^{cfg_read, bus.m_ready, bus.icb_rsp_rdata};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= QPU_DMA_ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wdata_q <= '0;
`ifdef QPU_DTCM_DMA_READ_EN
      mode_q  <= 1'b0;
      rdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wdata_q <= wdata_d;
`ifdef QPU_DTCM_DMA_READ_EN
      mode_q  <= mode_d;
      rdata_q <= rdata_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wdata_d = wdata_q;
`ifdef QPU_DTCM_DMA_READ_EN
    mode_d  = mode_q;
    rdata_d = rdata_q;
`endif
    case (state_q)
      QPU_DMA_ST_IDLE: begin
        if (cfg_start) begin
          addr_d = word_align(cfg_base);
          rem_d  = cfg_len;
`ifdef QPU_DTCM_DMA_READ_EN
          mode_d = cfg_read;
          if (cfg_len == '0)   state_d = QPU_DMA_ST_DONE;
          else if (cfg_read)   state_d = QPU_DMA_ST_CMD;
          else                 state_d = QPU_DMA_ST_FETCH;
`else
          state_d = (cfg_len == '0) ? QPU_DMA_ST_DONE : QPU_DMA_ST_FETCH;
`endif
        end
      end
      QPU_DMA_ST_FETCH: begin
        if (bus.s_valid) begin
          wdata_d = bus.s_data;
          state_d = QPU_DMA_ST_CMD;
        end
      end
      QPU_DMA_ST_CMD: begin
        if (bus.icb_cmd_ready) state_d = QPU_DMA_ST_RSP;
      end
      QPU_DMA_ST_RSP: begin
        if (bus.icb_rsp_valid) begin
          addr_d = addr_q + AW'(4);
          rem_d  = rem_q - LEN_W'(1);
`ifdef QPU_DTCM_DMA_READ_EN
          if (mode_q) begin
            rdata_d = bus.icb_rsp_rdata;
            state_d = QPU_DMA_ST_PUSH;
          end else
`endif
          // rem_q still holds the pre-decrement count here
          state_d = (rem_q == LEN_W'(1)) ? QPU_DMA_ST_DONE : QPU_DMA_ST_FETCH;
        end
      end
`ifdef QPU_DTCM_DMA_READ_EN
      QPU_DMA_ST_PUSH: begin
        if (bus.m_ready) state_d = (rem_q == '0) ? QPU_DMA_ST_DONE : QPU_DMA_ST_CMD;
      end
`endif
      QPU_DMA_ST_DONE: state_d = QPU_DMA_ST_IDLE;
      default:         state_d = QPU_DMA_ST_IDLE;
    endcase
  end

  assign busy              = (state_q != QPU_DMA_ST_IDLE);
  assign done              = (state_q == QPU_DMA_ST_DONE);
  assign dma_active        = busy | cfg_start;
  assign bus.s_ready       = (state_q == QPU_DMA_ST_FETCH);
  assign bus.icb_cmd_valid = (state_q == QPU_DMA_ST_CMD);
  assign bus.icb_rsp_ready = (state_q == QPU_DMA_ST_RSP);
  assign bus.icb_cmd_addr  = addr_q;
  assign bus.icb_cmd_wdata = wdata_q;
  assign bus.icb_cmd_wmask = 4'hF;
`ifdef QPU_DTCM_DMA_READ_EN
  assign bus.m_valid       = (state_q == QPU_DMA_ST_PUSH);
  assign bus.m_data        = rdata_q;
  assign bus.icb_cmd_read  = mode_q;
`else
  assign bus.m_valid       = 1'b0;
  assign bus.m_data        = '0;
  assign bus.icb_cmd_read  = 1'b0;
`endif

endmodule

// File: tb/tb_qpu_dtcm_dma.sv
// tb/tb_qpu_dtcm_dma.sv - directed scoreboard bench for qpu_dtcm_dma (read-mode steps need QPU_DTCM_DMA_READ_EN).
module tb_qpu_dtcm_dma;
  import qpu_dtcm_dma_pkg::*;

  localparam int AW = QPU_DTCM_ADDR_WIDTH;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          rd;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start, cfg_read;
  logic [AW-1:0] cfg_base;
  logic [15:0]   cfg_len;
  logic          busy, done, dma_active;

  qpu_dtcm_dma_if bus ();

  qpu_dtcm_dma dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_read(cfg_read),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .busy(busy), .done(done),
    .dma_active(dma_active), .bus(bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cmd_count = 0;
  cmd_t        exp_cmd_q[$];
  logic [31:0] exp_m_q[$];
  logic [31:0] src_q[$];
  logic [31:0] mem [int];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // DTCM model and command scoreboard; a handshake seen at negedge completes at the next posedge
  always @(negedge clk) begin
    if (rst_n && bus.icb_cmd_valid && bus.icb_cmd_ready) begin
      cmd_t c;
      cmd_count++;
      if (exp_cmd_q.size() == 0) begin
        check("unexpected_cmd", {32'(bus.icb_cmd_addr), 32'(bus.icb_cmd_read)}, 64'hDEAD);
      end else begin
        c = exp_cmd_q.pop_front();
        check("cmd_addr", 64'(bus.icb_cmd_addr), 64'(c.addr));
        check("cmd_read", 64'(bus.icb_cmd_read), 64'(c.rd));
        check("cmd_wmask", 64'(bus.icb_cmd_wmask), 64'hF);
        if (!c.rd) check("cmd_wdata", 64'(bus.icb_cmd_wdata), 64'(c.wdata));
      end
      if (bus.icb_cmd_read) bus.icb_rsp_rdata = mem[int'(bus.icb_cmd_addr)];
      else                  mem[int'(bus.icb_cmd_addr)] = bus.icb_cmd_wdata;
    end
    if (rst_n && bus.m_valid && bus.m_ready) begin
      if (exp_m_q.size() == 0) check("unexpected_m_beat", 64'(bus.m_data), 64'hDEAD);
      else                     check("m_data", 64'(bus.m_data), 64'(exp_m_q.pop_front()));
    end
    if (rst_n && bus.s_ready && bus.s_valid) void'(src_q.pop_front());
  end

  always @(posedge clk) begin
    #1;
    bus.s_valid = (src_q.size() > 0);
    bus.s_data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic rd, input logic [AW-1:0] base, input logic [15:0] len);
    cfg_read  = rd;
    cfg_base  = base;
    cfg_len   = len;
    cfg_start = 1'b1;
    #1;
    check("dma_active_on_start", 64'(dma_active), 64'h1);
    tick();
    cfg_start = 1'b0;
    check("busy_after_start", 64'(busy), 64'h1);
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    check("done_within_bound", 64'(done), 64'h1);
  endtask

  task automatic wait_sig(input string tag, input int which, input int bound);
    int n = 0;
    while (n < bound && !((which == 0) ? bus.icb_cmd_valid :
                          (which == 1) ? bus.icb_rsp_ready : bus.m_valid)) begin
      tick();
      n++;
    end
    check(tag, 64'(n < bound), 64'h1);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
    cmd_t c;
    c.addr = a; c.wdata = d; c.rd = 1'b0;
    exp_cmd_q.push_back(c);
    src_q.push_back(d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'h0);
    check({tag, "_done"}, 64'(done), 64'h0);
    check({tag, "_dma_active"}, 64'(dma_active), 64'h0);
    check({tag, "_valids"}, {60'h0, bus.s_ready, bus.m_valid, bus.icb_cmd_valid, bus.icb_rsp_ready}, 64'h0);
    check({tag, "_cmd_read"}, 64'(bus.icb_cmd_read), 64'h0);
    check({tag, "_m_data"}, 64'(bus.m_data), 64'h0);
    check({tag, "_addr"}, 64'(bus.icb_cmd_addr), 64'h0);
    check({tag, "_wdata"}, 64'(bus.icb_cmd_wdata), 64'h0);
    check({tag, "_wmask"}, 64'(bus.icb_cmd_wmask), 64'hF);
  endtask

  initial begin
    int            n;
    logic [AW-1:0] held_addr;
    logic [31:0]   held_data;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_read = 1'b0; cfg_base = '0; cfg_len = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
    bus.icb_cmd_ready = 1'b1; bus.icb_rsp_valid = 1'b1; bus.icb_rsp_rdata = '0;
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // three-word write, zero wait states
    push_wr(16'h0010, 32'hA); push_wr(16'h0014, 32'hB); push_wr(16'h0018, 32'hC);
    start(1'b0, 16'h0010, 16'd3);
    check("write_first_fetch", 64'(bus.s_ready), 64'h1);
    wait_done(40, n);
    check("write_done_latency", 64'(n), 64'd9);
    tick();
    check("write_done_pulse_width", {62'h0, done, busy}, 64'h0);
    check("write_mem", {mem[32'h10], mem[32'h18]}, {32'hA, 32'hC});
    check("write_sb_empty", 64'(exp_cmd_q.size()), 64'h0);

`ifdef QPU_DTCM_DMA_READ_EN
    // two-word read with a stalled sink
    begin
      cmd_t c;
      mem[32'h100] = 32'h11; mem[32'h104] = 32'h22;
      c.addr = 16'h0100; c.wdata = '0; c.rd = 1'b1; exp_cmd_q.push_back(c);
      c.addr = 16'h0104; exp_cmd_q.push_back(c);
      exp_m_q.push_back(32'h11); exp_m_q.push_back(32'h22);
      bus.m_ready = 1'b0;
      start(1'b1, 16'h0102, 16'd2);
      wait_sig("read_m_valid_seen", 2, 20);
      held_data = bus.m_data;
      check("read_first_word", 64'(held_data), 64'h11);
      for (int i = 0; i < 4; i++) begin
        tick();
        check("read_push_hold", {31'h0, bus.m_valid, held_data}, {31'h0, 1'b1, bus.m_data});
        check("read_no_cmd_in_push", 64'(bus.icb_cmd_valid), 64'h0);
      end
      bus.m_ready = 1'b1;
      wait_done(40, n);
      tick();
      check("read_sb_empty", {32'(exp_cmd_q.size()), 32'(exp_m_q.size())}, 64'h0);
    end
`else
    // without read support cfg_read must be ignored and the transfer runs as a write
    push_wr(16'h0020, 32'h5A5A);
    start(1'b1, 16'h0020, 16'd1);
    check("noread_is_write", {62'h0, bus.s_ready, bus.icb_cmd_valid}, 64'h2);
    wait_done(20, n);
    tick();
    check("noread_mem", 64'(mem[32'h20]), 64'h5A5A);
`endif

    // zero-length transfer
    n = cmd_count;
    start(1'b0, 16'h0040, 16'd0);
    check("len0_done", {62'h0, done, busy}, 64'h3);
    tick();
    check("len0_busy_1cycle", {62'h0, done, busy}, 64'h0);
    check("len0_no_cmd", 64'(cmd_count), 64'(n));

    // address wrap from the top word; bits [1:0] of the base are dropped
    push_wr(16'hFFFC, 32'h55); push_wr(16'h0000, 32'h66);
    start(1'b0, 16'hFFFF, 16'd2);
    wait_done(40, n);
    tick();
    check("wrap_mem", {mem[32'hFFFC], mem[32'h0]}, {32'h55, 32'h66});

    // cmd_ready stall with a stray start pulse mid-transfer
    n = cmd_count;
    push_wr(16'h0200, 32'h1234); push_wr(16'h0204, 32'h5678);
    bus.icb_cmd_ready = 1'b0;
    start(1'b0, 16'h0200, 16'd2);
    wait_sig("stall_cmd_seen", 0, 20);
    held_addr = bus.icb_cmd_addr;
    held_data = bus.icb_cmd_wdata;
    for (int i = 0; i < 5; i++) begin
      cfg_start = (i == 2);
      cfg_base  = 16'h0800;
      cfg_len   = 16'd5;
      tick();
      check("stall_payload", {15'h0, bus.icb_cmd_valid, held_addr, held_data},
            {15'h0, 1'b1, bus.icb_cmd_addr, bus.icb_cmd_wdata});
    end
    cfg_start = 1'b0;
    bus.icb_cmd_ready = 1'b1;
    wait_done(40, n);
    tick(); tick();
    check("stall_word_count", {31'h0, busy, 32'(exp_cmd_q.size())}, 64'h0);
    check("stall_mem", {mem[32'h200], mem[32'h204]}, {32'h1234, 32'h5678});

    // asynchronous reset while waiting for a response
    bus.icb_rsp_valid = 1'b0;
    push_wr(16'h0300, 32'h77);
    start(1'b0, 16'h0300, 16'd1);
    wait_sig("rsp_state_seen", 1, 20);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick();
    rst_n = 1'b1;
    bus.icb_rsp_valid = 1'b1;
    tick();
    push_wr(16'h0304, 32'h99);
    start(1'b0, 16'h0304, 16'd1);
    wait_done(20, n);
    check("post_reset_latency", 64'(n), 64'd3);
    tick();
    check("post_reset_mem", 64'(mem[32'h304]), 64'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
